// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BR = 2'd0,
        J  = 2'd1,
        JR = 2'd2
    } redir_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // When full, a simultaneous push lands in the slot the pop just vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem req/ack handshake, fetch FIFO, redirects.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirect targets on fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redir_valid,
    input  logic [1:0]      redir_kind,
    input  logic [XLEN-1:0] redir_pc,
    input  logic [25:0]     redir_imm,
    input  logic [XLEN-1:0] redir_reg,
    output logic            fault
);
    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  br_off;
    logic [XLEN-1:0]  target_raw;
    logic [XLEN-1:0]  target;
    logic             ack_push;
    logic             pop_now;
    logic             push;
    logic [XLEN+31:0] fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        seq_pc     = redir_pc + STEP;
        br_off     = {{(XLEN-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
        target_raw = redir_reg;
        case (redir_kind_t'(redir_kind))
            BR:      target_raw = seq_pc + br_off;
            J:       target_raw = {seq_pc[XLEN-1:28], redir_imm, 2'b00};
            default: target_raw = redir_reg;
        endcase
        target = target_raw & ALIGN_MASK;
    end

    assign ack_push = (state == REQ) && imem_ack && !redir_valid;
    assign pop_now  = inst_ready && !fifo_empty;
    assign push     = ack_push && (!fifo_full || pop_now);

    // pc holds the next address to issue; imem_addr stays frozen through REQ/DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redir_valid) begin
                        pc <= target;
                    end else if (fifo_count < DEPTH_C) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        pc       <= redir_valid ? target : pc + STEP;
                    end else if (redir_valid) begin
                        state <= DROP;
                        pc    <= target;
                    end
                end
                DROP: begin
                    if (redir_valid) pc <= target;
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (inst_ready),
        .flush     (redir_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_head[31:0];
    assign inst_pc    = fifo_head[XLEN+31:32];

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redir_valid && (target_raw != target)) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem responder model plus an {pc, instr} scoreboard.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_kind = '0;
    logic [31:0] redir_pc = '0;
    logic [25:0] redir_imm = '0;
    logic [31:0] redir_reg = '0;
    logic        fault;

    entry_t sb[$];
    int     errors = 0;
    int     checks = 0;
    int     ack_count = 0;
    int     wait_cnt = -1;
    int     fixed_lat = -1;
    bit     mem_hold = 1'b0;
    bit     auto_rdy = 1'b0;
    int     pop_credit = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_kind  (redir_kind),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_reg   (redir_reg),
        .fault       (fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            sb.push_back({a, mem_word(a)});
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        auto_rdy = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        auto_rdy = 1'b0;
        chk(tag, 32'(sb.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic redirect(input logic [1:0] k, input logic [31:0] p,
                            input logic [25:0] imm, input logic [31:0] r);
        @(negedge clk);
        redir_valid = 1'b1;
        redir_kind  = k;
        redir_pc    = p;
        redir_imm   = imm;
        redir_reg   = r;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    // Instruction memory: acks a pending request after 0..3 cycles (or fixed_lat).
    initial begin
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req && !mem_hold) begin
                if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    ack_count++;
                    wait_cnt   = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Decode side: the head is checked on the negedge before the edge that accepts it.
    initial begin
        bit     want;
        entry_t e;
        forever begin
            @(negedge clk);
            want = (sb.size() > 0) && (auto_rdy || pop_credit > 0);
            inst_ready = want;
            if (want && inst_valid) begin
                e = sb.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_data", inst_data, e.data);
                if (pop_credit > 0) pop_credit--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);

        // Random-latency stream of 8 instructions from reset.
        expect_seq(32'h0, 8);
        rst_n = 1'b1;
        drain("t1_drain", 300);

        // Decode stalled: FIFO fills to DEPTH and fetch stops.
        chk("stall_acks", 32'(ack_count), 32'd12);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(inst_valid), 32'd1);
        chk("stall_head", inst_pc, 32'h20);
        expect_seq(32'h20, 1);
        pop_credit = 1;
        repeat (15) @(negedge clk);
        chk("stall_popped", 32'(sb.size()), 32'd0);
        chk("stall_one_more", 32'(ack_count), 32'd13);
        chk("stall_req2", 32'(imem_req), 32'd0);
        repeat (5) @(negedge clk);
        chk("stall_no_more", 32'(ack_count), 32'd13);

        // BR backwards: 0x100 + 4 - 8.
        redirect(2'd0, 32'h100, 26'h000FFFE, 32'h0);
        chk("br_flush", 32'(inst_valid), 32'd0);
        expect_seq(32'h0000_00FC, 2);
        drain("br_drain", 100);

        // J keeps the upper nibble of pc+4.
        redirect(2'd1, 32'hF000_0010, 26'h40, 32'h0);
        chk("j_flush", 32'(inst_valid), 32'd0);
        expect_seq(32'hF000_0100, 2);
        drain("j_drain", 100);

        // JR near the top of the address space: pc wraps to 0.
        redirect(2'd2, 32'h0, 26'h0, 32'hFFFF_FFF8);
        chk("jr_flush", 32'(inst_valid), 32'd0);
        expect_seq(32'hFFFF_FFF8, 4);
        drain("wrap_drain", 150);

        // Reserved kind behaves as JR.
        redirect(2'd3, 32'h1234_0000, 26'h3FF_FFFF, 32'h300);
        chk("rsv_flush", 32'(inst_valid), 32'd0);
        expect_seq(32'h300, 2);
        drain("rsv_drain", 100);

        // Redirect while the request to 0x20 is outstanding.
        mem_hold = 1'b1;
        redirect(2'd2, 32'h0, 26'h0, 32'h20);
        n = 0;
        while (!(imem_req && imem_addr == 32'h20) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr0", imem_addr, 32'h20);
        redirect(2'd2, 32'h0, 26'h0, 32'h400);
        chk("drop_req_held", 32'(imem_req), 32'd1);
        chk("drop_addr_held", imem_addr, 32'h20);
        repeat (2) @(negedge clk);
        chk("drop_addr_held2", imem_addr, 32'h20);
        fixed_lat = 0;
        mem_hold  = 1'b0;
        expect_seq(32'h400, 2);
        drain("drop_drain", 100);
        fixed_lat = -1;

        // Back-to-back redirects: the second target wins.
        @(negedge clk);
        redir_valid = 1'b1;
        redir_kind  = 2'd2;
        redir_reg   = 32'h500;
        @(negedge clk);
        redir_reg   = 32'h600;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("b2b_flush", 32'(inst_valid), 32'd0);
        expect_seq(32'h600, 2);
        drain("b2b_drain", 100);

        // Misaligned JR target: low bits dropped, fault only with the check built in.
        chk("fault_pre", 32'(fault), 32'd0);
        redirect(2'd2, 32'h0, 26'h0, 32'h202);
`ifdef FETCH_ALIGN_CHK_EN
        chk("fault_set", 32'(fault), 32'd1);
`else
        chk("fault_set", 32'(fault), 32'd0);
`endif
        expect_seq(32'h200, 2);
        drain("align_drain", 100);
`ifdef FETCH_ALIGN_CHK_EN
        chk("fault_sticky", 32'(fault), 32'd1);
`else
        chk("fault_sticky", 32'(fault), 32'd0);
`endif

        // Reset mid-stream clears everything.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_valid", 32'(inst_valid), 32'd0);
        chk("rst2_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the MIPS core.
- Owns the PC register and issues requests to a variable-latency instruction memory with a req/ack handshake.
- Buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
- Computes redirect targets for beq/bne, j/jal and jr, and flushes all wrong-path state on a redirect.

Parameters:
- XLEN, 32, data and address width in bits; must be ≥ 32.
- DEPTH, 4, fetch FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- imem_req  out  1  request valid; held high until imem_ack.
- imem_addr  out  XLEN  word-aligned fetch address; stable while imem_req is high.
- imem_ack  in  1  one-cycle response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head entry.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  head instruction address.
- redir_valid  in  1  redirect from execute, single-cycle pulse.
- redir_kind  in  2  0 = BR, 1 = J, 2 = JR, 3 = reserved (treated as JR).
- redir_pc  in  XLEN  address of the redirecting instruction.
- redir_imm  in  26  instruction bits [25:0].
- redir_reg  in  XLEN  rs value, used for JR.
- fault  out  1  misaligned redirect target (see Optional Feature).

Behaviour:
- Reset values:
  - pc = RESET_PC; FSM = IDLE.
  - FIFO empty; all outputs 0.
  - imem_addr = RESET_PC.
- Redirect target arithmetic, all modulo 2^XLEN:
  - BR: redir_pc + 4 + (sext(redir_imm[15:0]) << 2).
  - J: {(redir_pc + 4)[XLEN-1:28], redir_imm, 2'b00}.
  - JR: redir_reg.
- FSM states and transitions:
  - IDLE → REQ when (FIFO count + outstanding) < DEPTH.
  - REQ: imem_req = 1, imem_addr = pc. On imem_ack: push {pc, imem_rdata}, pc += 4, return to IDLE. A new request is issued the following cycle, giving a 1-bubble minimum.
  - Redirect while in REQ with no ack that cycle → DROP.
  - DROP: imem_req stays high at the old address until imem_ack. The response is discarded, then → IDLE with pc = target.
- Redirect rules:
  - Redirect in any state flushes the FIFO in the same cycle, so inst_valid = 0 next cycle.
  - The latched target is applied at the next issue.
- Simultaneous events:
  - redir_valid with imem_ack: the ack data is discarded, pc = target, → IDLE.
  - redir_valid with inst_ready pop: flush wins; the popped head was already consumed by decode that cycle.
  - Push and pop in the same cycle with the FIFO full: legal; count is unchanged.
  - Back-to-back redirects: the last one wins.
- inst_valid/inst_data/inst_pc are registered FIFO outputs. The first instruction appears at the earliest 1 cycle after imem_ack.
- PC wraps from 2^XLEN - 4 to 0 with no flag.
- Asserting rst_n mid-request abandons the request. An imem_ack arriving while not in REQ/DROP is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect target with bits [1:0] != 0 sets fault (sticky until reset).
  - The target is still applied with bits [1:0] forced to 0.
- Undefined:
  - fault tied to 0.
  - Target low bits forced to 0 silently.

Decomposition:
- Shared package fetch_pkg:
  - redir_kind_t enum (BR, J, JR).
  - fetch_state_t (IDLE, REQ, DROP).
  - Constant INSTR_BYTES = 4.
- Sub-module fetch_fifo (DEPTH, width XLEN+32):
  - Synchronous push/pop and a flush input.
  - Outputs count, full and empty.
  - Async active-low reset.

Test Plan:
- Reset, then imem ack latency 0..3 cycles random over 8 instructions → inst_pc 0x0, 0x4, …, 0x1C in order, data matches.
- inst_ready held 0 with DEPTH=4 → exactly 4 acks, then imem_req stays low; one pop → one new request.
- BR redirect: redir_pc=0x100, imm16=0xFFFE → next inst_pc = 0xFC, FIFO flushed.
- J redirect: redir_pc=0xF000_0010, imm26=0x40 → next inst_pc = 0xF000_0100.
- Redirect while request to 0x20 is outstanding, ack arrives 3 cycles later → that data never appears on inst_*; next inst_pc = target.
- FETCH_ALIGN_CHK_EN defined, JR with redir_reg=0x202 → fault=1 (sticky), next inst_pc = 0x200.
